// File: rtl/rv_wb_arbiter_pkg.sv
// Shared types and constants for the two-port Wishbone arbiter (rv_wb_arbiter).
package rv_wb_pkg;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_SW = 4;
  localparam int unsigned WB_TW = 16;

  localparam logic [WB_SW-1:0] WB_SEL_WORD = 4'hF;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_BUS_D = 2'd1,
    WB_BUS_I = 2'd2,
    WB_DONE  = 2'd3
  } wb_state_e;

  typedef enum logic {
    GRANT_D = 1'b0,
    GRANT_I = 1'b1
  } wb_grant_e;

  // Payload driven onto the Wishbone master pins for one transaction
  typedef struct packed {
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
    logic             we;
    logic [WB_SW-1:0] sel;
  } wb_req_t;

endpackage

// File: rtl/rv_wb_arbiter_if.sv
// Port bundle of rv_wb_arbiter: data/instruction request ports plus the Wishbone master pins.
interface rv_wb_arbiter_if;
  import rv_wb_pkg::*;

  logic             i_d_req;
  logic [WB_AW-1:0] i_d_adr;
  logic [WB_DW-1:0] i_d_dat;
  logic             i_d_we;
  logic [WB_SW-1:0] i_d_sel;
  logic             o_d_ack;
  logic             o_d_err;
  logic [WB_DW-1:0] o_d_dat;

  logic             i_i_req;
  logic [WB_AW-1:0] i_i_adr;
  logic             o_i_ack;
  logic             o_i_err;
  logic [WB_DW-1:0] o_i_dat;

  logic [WB_AW-1:0] o_wb_adr;
  logic [WB_DW-1:0] o_wb_dat;
  logic             o_wb_we;
  logic [WB_SW-1:0] o_wb_sel;
  logic             o_wb_stb;
  logic             o_wb_cyc;
  logic [WB_DW-1:0] i_wb_dat;
  logic             i_wb_ack;

  // Arbiter view: it is the Wishbone master
  modport master (
    input  i_d_req, i_d_adr, i_d_dat, i_d_we, i_d_sel,
    output o_d_ack, o_d_err, o_d_dat,
    input  i_i_req, i_i_adr,
    output o_i_ack, o_i_err, o_i_dat,
    output o_wb_adr, o_wb_dat, o_wb_we, o_wb_sel, o_wb_stb, o_wb_cyc,
    input  i_wb_dat, i_wb_ack
  );

  // Environment view: requesters and the Wishbone slave
  modport slave (
    output i_d_req, i_d_adr, i_d_dat, i_d_we, i_d_sel,
    input  o_d_ack, o_d_err, o_d_dat,
    output i_i_req, i_i_adr,
    input  o_i_ack, o_i_err, o_i_dat,
    input  o_wb_adr, o_wb_dat, o_wb_we, o_wb_sel, o_wb_stb, o_wb_cyc,
    output i_wb_dat, i_wb_ack
  );

endinterface

// File: rtl/rv_wb_timeout.sv
// Transaction watchdog: counter cleared on grant, counts stalled bus cycles, flags LIMIT.
module rv_wb_timeout
  import rv_wb_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire_c
);

  logic [WB_TW-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + WB_TW'(1);
    end
  end

  assign o_expire_c = (r_count == WB_TW'(LIMIT));

endmodule

// File: rtl/rv_wb_arbiter.sv
// Two-port round-robin Wishbone master arbiter (data + instruction ports).
// Optional transaction timeout enabled by defining RV_WB_TIMEOUT_EN.
module rv_wb_arbiter
  import rv_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic            i_clk,
  input logic            i_reset,
  rv_wb_arbiter_if.master bus
);

  wb_state_e        r_state, w_state_nxt;
  wb_grant_e        r_last, w_last_nxt;
  wb_req_t          r_wb, w_wb_nxt;
  logic             r_cyc, w_cyc_nxt;
  logic             r_d_req, r_i_req;
  logic             r_d_ack, w_d_ack_nxt;
  logic             r_i_ack, w_i_ack_nxt;
  logic             r_d_err, w_d_err_nxt;
  logic             r_i_err, w_i_err_nxt;
  logic [WB_DW-1:0] r_d_dat, w_d_dat_nxt;
  logic [WB_DW-1:0] r_i_dat, w_i_dat_nxt;
  logic [WB_DW-1:0] w_rdat;
  logic             w_grant_d;
  logic             w_expire;

  // Data wins a tie only when instruction was granted last
  assign w_grant_d = r_d_req && (!r_i_req || (r_last == GRANT_I));

`ifdef RV_WB_TIMEOUT_EN
  logic w_tmo_clr;
  logic w_tmo_en;

  assign w_tmo_clr = (r_state == WB_IDLE) && (r_d_req || r_i_req);
  assign w_tmo_en  = ((r_state == WB_BUS_D) || (r_state == WB_BUS_I)) && !bus.i_wb_ack;

  rv_wb_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clr      (w_tmo_clr),
    .i_en       (w_tmo_en),
    .o_expire_c (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= WB_IDLE;
      r_last  <= GRANT_I;
      r_wb    <= '0;
      r_cyc   <= 1'b0;
      r_d_req <= 1'b0;
      r_i_req <= 1'b0;
      r_d_ack <= 1'b0;
      r_i_ack <= 1'b0;
      r_d_err <= 1'b0;
      r_i_err <= 1'b0;
      r_d_dat <= '0;
      r_i_dat <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_wb    <= w_wb_nxt;
      r_cyc   <= w_cyc_nxt;
      // Requests are only captured while idle, so a stale request never re-arbitrates
      r_d_req <= (r_state == WB_IDLE) && bus.i_d_req;
      r_i_req <= (r_state == WB_IDLE) && bus.i_i_req;
      r_d_ack <= w_d_ack_nxt;
      r_i_ack <= w_i_ack_nxt;
      r_d_err <= w_d_err_nxt;
      r_i_err <= w_i_err_nxt;
      r_d_dat <= w_d_dat_nxt;
      r_i_dat <= w_i_dat_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_wb_nxt    = r_wb;
    w_cyc_nxt   = r_cyc;
    w_d_ack_nxt = 1'b0;
    w_i_ack_nxt = 1'b0;
    w_d_err_nxt = 1'b0;
    w_i_err_nxt = 1'b0;
    w_d_dat_nxt = r_d_dat;
    w_i_dat_nxt = r_i_dat;
    w_rdat      = bus.i_wb_ack ? bus.i_wb_dat : '0;

    case (r_state)
      WB_IDLE: begin
        if (w_grant_d) begin
          w_state_nxt  = WB_BUS_D;
          w_last_nxt   = GRANT_D;
          w_cyc_nxt    = 1'b1;
          w_wb_nxt.adr = bus.i_d_adr;
          w_wb_nxt.dat = bus.i_d_dat;
          w_wb_nxt.we  = bus.i_d_we;
          w_wb_nxt.sel = bus.i_d_sel;
        end else if (r_i_req) begin
          w_state_nxt  = WB_BUS_I;
          w_last_nxt   = GRANT_I;
          w_cyc_nxt    = 1'b1;
          w_wb_nxt.adr = bus.i_i_adr;
          w_wb_nxt.dat = '0;
          w_wb_nxt.we  = 1'b0;
          w_wb_nxt.sel = WB_SEL_WORD;
        end
      end
      WB_BUS_D, WB_BUS_I: begin
        // Ack takes priority over a coincident timeout
        if (bus.i_wb_ack || w_expire) begin
          w_state_nxt = WB_DONE;
          w_cyc_nxt   = 1'b0;
          if (r_state == WB_BUS_D) begin
            w_d_ack_nxt = 1'b1;
            w_d_err_nxt = !bus.i_wb_ack;
            w_d_dat_nxt = w_rdat;
          end else begin
            w_i_ack_nxt = 1'b1;
            w_i_err_nxt = !bus.i_wb_ack;
            w_i_dat_nxt = w_rdat;
          end
        end
      end
      WB_DONE: w_state_nxt = WB_IDLE;
      default: w_state_nxt = WB_IDLE;
    endcase
  end

  assign bus.o_wb_adr = r_wb.adr;
  assign bus.o_wb_dat = r_wb.dat;
  assign bus.o_wb_we  = r_wb.we;
  assign bus.o_wb_sel = r_wb.sel;
  assign bus.o_wb_stb = r_cyc;
  assign bus.o_wb_cyc = r_cyc;
  assign bus.o_d_ack  = r_d_ack;
  assign bus.o_d_err  = r_d_err;
  assign bus.o_d_dat  = r_d_dat;
  assign bus.o_i_ack  = r_i_ack;
  assign bus.o_i_err  = r_i_err;
  assign bus.o_i_dat  = r_i_dat;

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Self-checking bench for rv_wb_arbiter: directed and random transactions against a
// round-robin/latency reference model and a behavioural Wishbone slave.
module tb_rv_wb_arbiter;

`ifdef RV_WB_TIMEOUT_EN
  localparam int T_LIMIT = 8;
`else
  localparam int T_LIMIT = 1 << 30;
`endif

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
    int          len;
    bit          stable;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  logic s_ack = 1'b0;
  logic stray_ack = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: last granted port (0 = D, 1 = I) and held read data per port
  int          m_last = 1;
  logic [31:0] m_ddat = '0;
  logic [31:0] m_idat = '0;

  // Slave programming and observation
  int          w_q[$];
  logic [31:0] rd_q[$];
  txn_t        log_q[$];
  bit          s_busy = 1'b0;
  int          s_wait = 0;
  txn_t        s_cur;

  rv_wb_arbiter_if bus ();

  rv_wb_arbiter #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  assign bus.i_wb_ack = s_ack | stray_ack;

  always #5 clk = ~clk;

  // Behavioural slave: per-transaction wait states from w_q, read data from rd_q
  always @(posedge clk) begin
    #1;
    if (bus.o_wb_cyc && bus.o_wb_stb) begin
      if (!s_busy) begin
        s_busy       = 1'b1;
        s_cur.adr    = bus.o_wb_adr;
        s_cur.dat    = bus.o_wb_dat;
        s_cur.we     = bus.o_wb_we;
        s_cur.sel    = bus.o_wb_sel;
        s_cur.len    = 0;
        s_cur.stable = 1'b1;
        s_wait       = (w_q.size() > 0) ? w_q.pop_front() : 0;
      end else if (bus.o_wb_adr !== s_cur.adr || bus.o_wb_dat !== s_cur.dat ||
                   bus.o_wb_we !== s_cur.we || bus.o_wb_sel !== s_cur.sel) begin
        s_cur.stable = 1'b0;
      end
      s_cur.len++;
      if (s_wait == 0) begin
        s_ack        = 1'b1;
        bus.i_wb_dat = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
      end else begin
        s_ack = 1'b0;
        s_wait--;
      end
    end else begin
      if (s_busy) log_q.push_back(s_cur);
      s_busy = 1'b0;
      s_ack  = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One arbitration round: model predicts grant order, ack cycles, data and bus payloads
  task automatic run(input string tag, input bit dq, input bit iq,
                     input logic [31:0] dadr, input logic [31:0] ddat, input bit dwe,
                     input logic [3:0] dsel, input logic [31:0] iadr,
                     input int wd, input int wi, input logic [31:0] rdd, input logic [31:0] rdi);
    int          ord[$];
    int          t_ack[2];
    int          e_eff[2];
    bit          e_err[2];
    logic [31:0] e_dat[2];
    int          t;
    int          tmax;
    int          p;
    int          w;
    txn_t        tx;
    t_ack[0] = -1;
    t_ack[1] = -1;
    if (dq && iq) begin
      if (m_last == 1) begin ord.push_back(0); ord.push_back(1); end
      else begin ord.push_back(1); ord.push_back(0); end
    end else if (dq) ord.push_back(0);
    else if (iq) ord.push_back(1);
    t = 0;
    foreach (ord[k]) begin
      p        = ord[k];
      w        = (p == 0) ? wd : wi;
      e_eff[p] = (w > T_LIMIT) ? T_LIMIT : w;
      e_err[p] = (w > T_LIMIT);
      t       += ((k == 0) ? 3 : 4) + e_eff[p];
      t_ack[p] = t;
      e_dat[p] = e_err[p] ? 32'h0 : ((p == 0) ? rdd : rdi);
      w_q.push_back(w);
      if (!e_err[p]) rd_q.push_back((p == 0) ? rdd : rdi);
      m_last = p;
    end
    tmax = t + 1;

    bus.i_d_req = dq;  bus.i_d_adr = dadr; bus.i_d_dat = ddat;
    bus.i_d_we  = dwe; bus.i_d_sel = dsel;
    bus.i_i_req = iq;  bus.i_i_adr = iadr;
    for (int n = 1; n <= tmax; n++) begin
      @(negedge clk);
      check($sformatf("%s d_ack@%0d", tag, n), 32'(bus.o_d_ack), 32'(n == t_ack[0]));
      check($sformatf("%s i_ack@%0d", tag, n), 32'(bus.o_i_ack), 32'(n == t_ack[1]));
      if (n == t_ack[0]) begin
        check({tag, " d_dat"}, bus.o_d_dat, e_dat[0]);
        check({tag, " d_err"}, 32'(bus.o_d_err), 32'(e_err[0]));
        m_ddat = e_dat[0];
        bus.i_d_req = 1'b0;
      end
      if (n == t_ack[1]) begin
        check({tag, " i_dat"}, bus.o_i_dat, e_dat[1]);
        check({tag, " i_err"}, 32'(bus.o_i_err), 32'(e_err[1]));
        m_idat = e_dat[1];
        bus.i_i_req = 1'b0;
      end
    end
    repeat (2) @(negedge clk);

    check({tag, " cyc_idle"}, 32'(bus.o_wb_cyc), 32'h0);
    check({tag, " stb_idle"}, 32'(bus.o_wb_stb), 32'h0);
    check({tag, " d_hold"}, bus.o_d_dat, m_ddat);
    check({tag, " i_hold"}, bus.o_i_dat, m_idat);
    check({tag, " n_txn"}, 32'(log_q.size()), 32'(ord.size()));
    if (log_q.size() == ord.size()) begin
      foreach (ord[k]) begin
        tx = log_q.pop_front();
        p  = ord[k];
        check($sformatf("%s adr%0d", tag, k), tx.adr, (p == 0) ? dadr : iadr);
        check($sformatf("%s wdat%0d", tag, k), tx.dat, (p == 0) ? ddat : 32'h0);
        check($sformatf("%s we%0d", tag, k), 32'(tx.we), (p == 0) ? 32'(dwe) : 32'h0);
        check($sformatf("%s sel%0d", tag, k), 32'(tx.sel), (p == 0) ? 32'(dsel) : 32'hF);
        check($sformatf("%s len%0d", tag, k), 32'(tx.len), 32'(e_eff[p] + 1));
        check($sformatf("%s stable%0d", tag, k), 32'(tx.stable), 32'h1);
      end
    end
    log_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.i_d_req = 1'b0; bus.i_d_adr = '0; bus.i_d_dat = '0; bus.i_d_we = 1'b0; bus.i_d_sel = '0;
    bus.i_i_req = 1'b0; bus.i_i_adr = '0;
    repeat (2) @(negedge clk);
    check("rst cyc", 32'(bus.o_wb_cyc), 32'h0);
    check("rst stb", 32'(bus.o_wb_stb), 32'h0);
    check("rst adr", bus.o_wb_adr, 32'h0);
    check("rst wdat", bus.o_wb_dat, 32'h0);
    check("rst we_sel", {27'h0, bus.o_wb_we, bus.o_wb_sel}, 32'h0);
    check("rst acks", {28'h0, bus.o_d_ack, bus.o_i_ack, bus.o_d_err, bus.o_i_err}, 32'h0);
    check("rst d_dat", bus.o_d_dat, 32'h0);
    check("rst i_dat", bus.o_i_dat, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run("rd_single", 1, 0, 32'h1000_0004, 32'h0, 0, 4'hF, 32'h0, 0, 0, 32'hDEAD_BEEF, 32'h0);
    run("wr_wait2", 1, 0, 32'h2000_0010, 32'h0000_1234, 1, 4'b0011, 32'h0, 2, 0, 32'h5A5A_0001, 32'h0);
    run("ifetch", 0, 1, 32'h0, 32'h0, 0, 4'h0, 32'h8000_0100, 0, 1, 32'h0, 32'h0000_0013);
    run("cont_a", 1, 1, 32'h3000_0000, 32'hAAAA_0000, 1, 4'hC, 32'h8000_0200, 0, 0, 32'h1111_1111, 32'h2222_2222);
    run("cont_b", 1, 1, 32'h3000_0004, 32'hBBBB_0000, 0, 4'hF, 32'h8000_0204, 1, 2, 32'h3333_3333, 32'h4444_4444);

    // Ack strobes while idle must be ignored
    stray_ack = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check($sformatf("stray acks@%0d", n), {30'h0, bus.o_d_ack, bus.o_i_ack}, 32'h0);
      check($sformatf("stray cyc@%0d", n), 32'(bus.o_wb_cyc), 32'h0);
    end
    stray_ack = 1'b0;
    @(negedge clk);
    check("stray d_hold", bus.o_d_dat, m_ddat);
    check("stray i_hold", bus.o_i_dat, m_idat);

    for (int it = 0; it < 20; it++) begin
      int mode;
      mode = $urandom_range(0, 2);
      run($sformatf("rnd%0d", it), mode != 1, mode != 0, $urandom, $urandom,
          1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom);
    end

    // Reset during a wait-stated data transfer
    w_q.push_back(6);
    bus.i_d_req = 1'b1; bus.i_d_adr = 32'h4000_0000; bus.i_d_we = 1'b0; bus.i_d_sel = 4'hF;
    repeat (3) @(negedge clk);
    check("mrst cyc_pre", 32'(bus.o_wb_cyc), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("mrst cyc_async", 32'(bus.o_wb_cyc), 32'h0);
    check("mrst stb_async", 32'(bus.o_wb_stb), 32'h0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check($sformatf("mrst d_ack@%0d", n), 32'(bus.o_d_ack), 32'h0);
    end
    bus.i_d_req = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mrst d_ack_after", 32'(bus.o_d_ack), 32'h0);
    log_q.delete(); rd_q.delete(); w_q.delete();
    m_last = 1; m_ddat = '0; m_idat = '0;
    check("mrst d_dat", bus.o_d_dat, 32'h0);
    run("post_rst_tie", 1, 1, 32'h5000_0000, 32'h0, 0, 4'hF, 32'h8000_0300, 0, 0, 32'h7777_0000, 32'h8888_0000);

`ifdef RV_WB_TIMEOUT_EN
    run("tmo_i", 0, 1, 32'h0, 32'h0, 0, 4'h0, 32'h8000_0400, 0, 1000, 32'h0, 32'hFFFF_FFFF);
    run("tmo_recover", 0, 1, 32'h0, 32'h0, 0, 4'h0, 32'h8000_0404, 0, 0, 32'h0, 32'h0BAD_F00D);
    run("tmo_coincide", 1, 0, 32'h6000_0000, 32'h0, 0, 4'hF, 32'h0, 8, 0, 32'hC0DE_CAFE, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
